// File: rtl/sa_pkg.sv
// Shared constants and types for the 8x8 systolic-array sequencer.
// Optional feature macro used by sa_matmul_ctrl: SA_CTRL_PERF_EN.
package sa_pkg;

  localparam int unsigned N        = 8;
  localparam int unsigned FEED_LEN = 3 * N - 2;
  localparam int unsigned T_W      = $clog2(FEED_LEN);
  localparam int unsigned ROW_W    = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  typedef logic [T_W-1:0] t_cnt_t;

  localparam t_cnt_t T_LAST = t_cnt_t'(FEED_LEN - 1);

endpackage

// File: rtl/sa_matmul_ctrl_if.sv
// Host-side load port and job handshake of the systolic-array sequencer.
interface sa_matmul_ctrl_if
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                    ld_valid;
  logic                    ld_ready;
  logic                    ld_sel;
  logic [ROW_W-1:0]        ld_row;
  logic [DATA_WIDTH*N-1:0] ld_data;
  logic                    start;
  logic                    busy;
  logic                    done;

  modport master (
    output ld_valid, ld_sel, ld_row, ld_data, start,
    input  ld_ready, busy, done
  );

  modport slave (
    input  ld_valid, ld_sel, ld_row, ld_data, start,
    output ld_ready, busy, done
  );

endinterface

// File: rtl/sa_skew_feeder.sv
// Combinational diagonal-skew generator: row i of A and column j of B are
// delayed by i (resp. j) feed steps so operands meet in the right PE.
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                 feed_en,
  input  t_cnt_t                               t,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_buf,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_buf,
  output logic [DATA_WIDTH*N-1:0]              left_in,
  output logic [DATA_WIDTH*N-1:0]              top_in
);

  // Select A[i][t-i] and B[t-j][j]; t-i underflow wraps large and fails the range test.
  always_comb begin
    int unsigned k;
    k       = 0;
    left_in = '0;
    top_in  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = 32'(t) - i;
      if (feed_en && (k < N)) begin
        left_in[i*DATA_WIDTH +: DATA_WIDTH] = a_buf[ROW_W'(i)][k[ROW_W-1:0]];
        top_in[i*DATA_WIDTH +: DATA_WIDTH]  = b_buf[k[ROW_W-1:0]][ROW_W'(i)];
      end
    end
  end

endmodule

// File: rtl/sa_matmul_ctrl.sv
// Sequencer for the 8x8 output-stationary systolic array: operand buffers,
// job FSM (IDLE/CLEAR/FEED/DRAIN/DONE) and result capture register.
// Define SA_CTRL_PERF_EN to add the perf_jobs / perf_busy_cycles counters.
module sa_matmul_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH    = 16,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  sa_matmul_ctrl_if.slave           host,
  output logic                      arr_clear,
  output logic [DATA_WIDTH*N-1:0]   arr_left_in,
  output logic [DATA_WIDTH*N-1:0]   arr_top_in,
  input  logic [ACC_WIDTH*N*N-1:0]  arr_result,
  output logic [ACC_WIDTH*N*N-1:0]  res_out
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [15:0]               perf_jobs,
  output logic [31:0]               perf_busy_cycles
`endif
);

  localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  typedef logic [DC_W-1:0] dcnt_t;
  localparam dcnt_t D_LAST = dcnt_t'(DRAIN_CYCLES - 1);

  state_t state_q;
  t_cnt_t t_q;
  dcnt_t  dcnt_q;
  logic   busy_q;
  logic   done_q;
  logic   clear_q;
  logic   ld_acc;

  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_buf;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0] b_buf;

  assign ld_acc        = host.ld_valid & ~busy_q;
  assign host.ld_ready = ~busy_q;
  assign host.busy     = busy_q;
  assign host.done     = done_q;
  assign arr_clear     = clear_q | reset;

  // Operand buffers: one row written per accepted load, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_buf <= '0;
      b_buf <= '0;
    end else if (ld_acc) begin
      if (host.ld_sel) b_buf[host.ld_row] <= host.ld_data;
      else             a_buf[host.ld_row] <= host.ld_data;
    end
  end

  // Job FSM with registered busy/done/clear and the result capture register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      dcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      res_out <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= FEED;
          t_q     <= '0;
          clear_q <= 1'b0;
        end
        FEED: begin
          if (t_q == T_LAST) begin
            state_q <= DRAIN;
            t_q     <= '0;
            dcnt_q  <= '0;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt_q == D_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_out <= arr_result;
          end else begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (host.start) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          clear_q <= 1'b0;
        end
      endcase
    end
  end

  sa_skew_feeder #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_feeder (
    .feed_en (state_q == FEED),
    .t       (t_q),
    .a_buf   (a_buf),
    .b_buf   (b_buf),
    .left_in (arr_left_in),
    .top_in  (arr_top_in)
  );

`ifdef SA_CTRL_PERF_EN
  // Free-running wrap-around job and busy-cycle counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_jobs        <= '0;
      perf_busy_cycles <= '0;
    end else begin
      if (done_q) perf_jobs <= perf_jobs + 16'd1;
      if (busy_q) perf_busy_cycles <= perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_matmul_ctrl.sv
// Self-checking bench for sa_matmul_ctrl with a behavioural PE array as load.
module tb_sa_matmul_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          arr_clear;
  logic [63:0]   arr_left_in;
  logic [63:0]   arr_top_in;
  logic [1023:0] arr_result;
  logic [1023:0] res_out;
`ifdef SA_CTRL_PERF_EN
  logic [15:0]   perf_jobs;
  logic [31:0]   perf_busy_cycles;
`endif

  sa_matmul_ctrl_if #(.DATA_WIDTH(8)) host ();

  sa_matmul_ctrl #(
    .DATA_WIDTH  (8),
    .ACC_WIDTH   (16),
    .DRAIN_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (host),
    .arr_clear  (arr_clear),
    .arr_left_in(arr_left_in),
    .arr_top_in (arr_top_in),
    .arr_result (arr_result),
    .res_out    (res_out)
`ifdef SA_CTRL_PERF_EN
    ,
    .perf_jobs       (perf_jobs),
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  // ---------------- behavioural output-stationary PE grid ----------------
  logic signed [7:0] ph [8][8];
  logic signed [7:0] pv [8][8];
  logic [15:0]       acc[8][8];

  function automatic logic signed [7:0] ain(int i, int j);
    if (j == 0) return arr_left_in[i*8 +: 8];
    return ph[i][j-1];
  endfunction

  function automatic logic signed [7:0] bin(int i, int j);
    if (i == 0) return arr_top_in[j*8 +: 8];
    return pv[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (reset || arr_clear) begin
          ph[i][j]  <= '0;
          pv[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          ph[i][j]  <= ain(i, j);
          pv[i][j]  <= bin(i, j);
          acc[i][j] <= acc[i][j] + 16'(int'(ain(i, j)) * int'(bin(i, j)));
        end
      end
    end
  end

  always_comb begin
    arr_result = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        arr_result[(i*8+j)*16 +: 16] = acc[i][j];
  end

  // ---------------- reference model ----------------
  int ma[8][8];
  int mb[8][8];
  logic [1023:0] last_exp;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_res(int r, int c);
    int s = 0;
    for (int k = 0; k < 8; k++) s += ma[r][k] * mb[k][c];
    return 16'(s);
  endfunction

  function automatic logic [1023:0] exp_vec();
    logic [1023:0] v = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        v[(r*8+c)*16 +: 16] = exp_res(r, c);
    return v;
  endfunction

  function automatic logic [63:0] exp_left(int t);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (t - i >= 0 && t - i < 8) v[i*8 +: 8] = 8'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [63:0] exp_top(int t);
    logic [63:0] v = '0;
    for (int j = 0; j < 8; j++)
      if (t - j >= 0 && t - j < 8) v[j*8 +: 8] = 8'(mb[t-j][j]);
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = 0;
        mb[r][c] = 0;
      end
  endtask

  task automatic fill(input int av, input int bv);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = av;
        mb[r][c] = bv;
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = int'($urandom_range(255)) - 128;
        mb[r][c] = int'($urandom_range(255)) - 128;
      end
  endtask

  task automatic set_ld(input bit sel, input int row);
    logic [63:0] d = '0;
    for (int c = 0; c < 8; c++) d[c*8 +: 8] = sel ? 8'(mb[row][c]) : 8'(ma[row][c]);
    host.ld_valid = 1'b1;
    host.ld_sel   = sel;
    host.ld_row   = 3'(row);
    host.ld_data  = d;
  endtask

  task automatic load_row(input bit sel, input int row);
    set_ld(sel, row);
    @(negedge clk);
    host.ld_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < 8; r++) begin
      load_row(1'b0, r);
      load_row(1'b1, r);
    end
  endtask

  task automatic kick();
    host.start = 1'b1;
    @(negedge clk);
    host.start    = 1'b0;
    host.ld_valid = 1'b0;
  endtask

  // Called at the negedge of job cycle cyc0; returns at the negedge where done is seen.
  task automatic wait_check(input string tag, input int cyc0);
    int cyc = cyc0;
    while (cyc < 100) begin
      chk($sformatf("%s_left_c%0d", tag, cyc), arr_left_in, exp_left(cyc - 2));
      chk($sformatf("%s_top_c%0d", tag, cyc), arr_top_in, exp_top(cyc - 2));
      if (cyc == 1) begin
        chk({tag, "_clear"}, 64'(arr_clear), 64'd1);
        chk({tag, "_busy"}, 64'(host.busy), 64'd1);
      end
      if (host.done) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd26);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("%s_r%0dc%0d", tag, r, c), 64'(res_out[(r*8+c)*16 +: 16]), 64'(exp_res(r, c)));
    last_exp = exp_vec();
  endtask

  task automatic run(input string tag);
    load_all();
    kick();
    wait_check(tag, 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(host.done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt;
    host.ld_valid = 1'b0;
    host.ld_sel   = 1'b0;
    host.ld_row   = '0;
    host.ld_data  = '0;
    host.start    = 1'b0;
    reset         = 1'b1;
    clear_model();
    last_exp = '0;

    repeat (3) @(negedge clk);
    chk("rst_clear", 64'(arr_clear), 64'd1);
    chk("rst_busy", 64'(host.busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", 64'(host.done), 64'd0);
    chk("rst_ready", 64'(host.ld_ready), 64'd1);
    chk("rst_arrclr", 64'(arr_clear), 64'd0);
    chk("rst_left", arr_left_in, 64'd0);
    chk("rst_top", arr_top_in, 64'd0);
    chk("rst_res", 64'(res_out == '0), 64'd1);

    // Identity: last B row written in the same cycle as start.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = 8 * r + c;
      end
    for (int r = 0; r < 8; r++) load_row(1'b0, r);
    for (int r = 0; r < 7; r++) load_row(1'b1, r);
    set_ld(1'b1, 7);
    kick();
    wait_check("ident", 1);
    chk("ident_r2c5", 64'(res_out[(2*8+5)*16 +: 16]), 64'd21);
    @(negedge clk);

    fill(1, 2);       run("const");
    chk("const_r7c7", 64'(res_out[63*16 +: 16]), 64'd16);
    fill(-1, 127);    run("neg");
    chk("neg_r0c0", 64'(res_out[15:0]), 64'(16'hFC08));
    fill(-128, -128); run("wrap");
    fill_rand();      run("rnd0");
    fill_rand();      run("rnd1");

    // Overlap: load and start while busy must be dropped.
    fill_rand();
    load_all();
    kick();
    repeat (5) @(negedge clk);
    chk("ovl_ready", 64'(host.ld_ready), 64'd0);
    host.ld_valid = 1'b1;
    host.ld_sel   = 1'b0;
    host.ld_row   = 3'd3;
    host.ld_data  = '1;
    host.start    = 1'b1;
    @(negedge clk);
    host.ld_valid = 1'b0;
    host.start    = 1'b0;
    chk("ovl_hold", 64'(res_out == last_exp), 64'd1);
    wait_check("ovl", 7);
    @(negedge clk);
    @(negedge clk);
    chk("ovl_noqueue", 64'(host.busy), 64'd0);
    kick();
    wait_check("ovl_buf", 1);
    @(negedge clk);

    // Back-to-back with start held across DONE.
    fill_rand();
    load_all();
    host.start = 1'b1;
    @(negedge clk);
    wait_check("b2b1", 1);
    @(negedge clk);
    wait_check("b2b2", 1);
    host.start = 1'b0;
    @(negedge clk);
    chk("b2b_idle", 64'(host.busy), 64'd0);
    @(negedge clk);

    // Abort in FEED at t=10.
    fill_rand();
    load_all();
    kick();
    repeat (11) @(negedge clk);
    chk("abort_left_t10", arr_left_in, exp_left(10));
    chk("abort_top_t10", arr_top_in, exp_top(10));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(host.busy), 64'd0);
    chk("abort_ready", 64'(host.ld_ready), 64'd1);
    chk("abort_res", 64'(res_out == '0), 64'd1);
    clear_model();
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (host.done) cnt++;
    end
    chk("abort_nodone", 64'(cnt), 64'd0);
    // Only A reloaded: a cleared B must give an all-zero product.
    fill(1, 0);
    for (int r = 0; r < 8; r++) load_row(1'b0, r);
    kick();
    wait_check("post_abort", 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
